// File: rtl/ads1299_frame_reader.sv
// ads1299_frame_reader: waits for ADS1299 DRDY, clocks one RDATAC frame
// (status word + N_CH channel words) over SPI mode 1 and emits the selected
// channel sign-extended to Q_out bits with a one-cycle valid strobe.
module ads1299_frame_reader #(
  parameter int CLK_DIV = 4,
  parameter int N_CH    = 8,
  parameter int CH_SEL  = 0,
  parameter int Q_out   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             drdy_n,
  input  logic             miso,
  output logic             sclk,
  output logic             cs_n,
  output logic [Q_out-1:0] x,
  output logic             x_valid,
  output logic [23:0]      status,
  output logic             overrun
);

  localparam int FB    = 24 * (N_CH + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FB);
  localparam int CH_LO = 24 * (CH_SEL + 1);
  localparam int CH_HI = CH_LO + 23;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FB - 1);
  localparam logic [BIT_W-1:0] STAT_END = BIT_W'(24);
  localparam logic [BIT_W-1:0] CH_LO_B  = BIT_W'(CH_LO);
  localparam logic [BIT_W-1:0] CH_HI_B  = BIT_W'(CH_HI);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  // 24-bit two's complement word widened to the output width
  function automatic logic [Q_out-1:0] sext24(input logic [23:0] v);
    logic signed [23:0] s;
    s = v;
    return Q_out'(s);
  endfunction

  logic drdy_s1_q, drdy_s2_q, drdy_dly_q;
  logic miso_s1_q, miso_s2_q;
  logic trig;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             phase_q, phase_d;   // 1 = SCLK high phase
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             xv_q, xv_d;
  logic [Q_out-1:0] x_q, x_d;
  logic [23:0]      status_q, status_d;
  logic             ovr_q, ovr_d;
  logic [23:0]      st_sr_q, st_sr_d;
  logic [23:0]      ch_sr_q, ch_sr_d;
  logic             sample;

  // Two-flop synchronizers for DRDY and MISO, plus a DRDY delay tap for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drdy_s1_q  <= 1'b1;
      drdy_s2_q  <= 1'b1;
      drdy_dly_q <= 1'b1;
      miso_s1_q  <= 1'b0;
      miso_s2_q  <= 1'b0;
    end else begin
      drdy_s1_q  <= drdy_n;
      drdy_s2_q  <= drdy_s1_q;
      drdy_dly_q <= drdy_s2_q;
      miso_s1_q  <= miso;
      miso_s2_q  <= miso_s1_q;
    end
  end

  assign trig = drdy_dly_q & ~drdy_s2_q;

  // Next-state, counters, word capture and registered output values
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    xv_d     = 1'b0;
    x_d      = x_q;
    status_d = status_q;
    ovr_d    = ovr_q;
    st_sr_d  = st_sr_q;
    ch_sr_d  = ch_sr_q;
    sample   = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig && enable) begin
          state_d = SETUP;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT;
          div_d   = '0;
          phase_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (phase_q) begin
            // last cycle of the high phase: SCLK is about to fall
            sample  = 1'b1;
            phase_d = 1'b0;
          end else if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + 1'b1;
            phase_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d = DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A DRDY edge during a frame is flagged and otherwise dropped
    if (trig && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    // Only the status word and the selected channel are kept
    if (sample) begin
      if (bit_q < STAT_END) begin
        st_sr_d = {st_sr_q[22:0], miso_s2_q};
      end
      if ((bit_q >= CH_LO_B) && (bit_q <= CH_HI_B)) begin
        ch_sr_d = {ch_sr_q[22:0], miso_s2_q};
      end
    end

    if (state_d == DONE) begin
      xv_d     = 1'b1;
      x_d      = sext24(ch_sr_q);
      status_d = st_sr_q;
    end

    sclk_d = (state_d == SHIFT) && phase_d;
    cs_n_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
  end

  // Control state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      xv_q     <= 1'b0;
      x_q      <= '0;
      status_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      xv_q     <= xv_d;
      x_q      <= x_d;
      status_q <= status_d;
      ovr_q    <= ovr_d;
    end
  end

  // Capture shift registers; fully rewritten by every frame, so no reset
  always_ff @(posedge clk) begin
    st_sr_q <= st_sr_d;
    ch_sr_q <= ch_sr_d;
  end

  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign x       = x_q;
  assign x_valid = xv_q;
  assign status  = status_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_ads1299_frame_reader.sv
// Testbench for ads1299_frame_reader: three parameterisations share DRDY and
// enable; each has its own ADS1299 model, reset and scoreboard monitor.
`timescale 1ns/1ps
module tb_ads1299_frame_reader;

  localparam int P_CD [3] = '{4, 4, 5};
  localparam int P_NC [3] = '{8, 8, 1};
  localparam int P_CS [3] = '{0, 2, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic enable = 1'b1;
  logic drdy_n = 1'b1;
  logic rst_n [3] = '{1'b0, 1'b0, 1'b0};

  logic        sclk_a [3];
  logic        cs_n_a [3];
  logic        xv_a   [3];
  logic        ovr_a  [3];
  logic [31:0] x_a    [3];
  logic [23:0] st_a   [3];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  int got        [3] = '{0, 0, 0};
  int exp_deliv  [3] = '{0, 0, 0};
  int cs_falls   [3] = '{0, 0, 0};
  int exp_starts [3] = '{0, 0, 0};
  int stray      [3] = '{0, 0, 0};
  logic [31:0] x_last  [3];
  logic [23:0] st_last [3];
  logic        ovr_exp [3] = '{1'b0, 1'b0, 1'b0};

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, inst, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int CD = P_CD[g];
    localparam int NC = P_NC[g];
    localparam int CS = P_CS[g];
    localparam int FB = 24 * (NC + 1);

    logic        miso_l = 1'b0;
    logic [55:0] q[$];
    int          w [9];
    int          idx = 0;
    int          fno = 0;
    int          t_start = 0;
    int          sr = 0;
    int          run = 0;
    int          pbad = 0;
    logic        pcs = 1'b1;
    logic        psclk = 1'b0;
    logic        pxv = 1'b0;

    ads1299_frame_reader #(.CLK_DIV(CD), .N_CH(NC), .CH_SEL(CS), .Q_out(32)) dut (
      .clk     (clk),
      .reset_n (rst_n[g]),
      .enable  (enable),
      .drdy_n  (drdy_n),
      .miso    (miso_l),
      .sclk    (sclk_a[g]),
      .cs_n    (cs_n_a[g]),
      .x       (x_a[g]),
      .x_valid (xv_a[g]),
      .status  (st_a[g]),
      .overrun (ovr_a[g])
    );

    // ADS1299 model: new frame words on CS fall, expected result queued
    always @(negedge cs_n_a[g]) begin
      int v;
      logic [31:0] xe;
      logic [23:0] se;
      fno++;
      for (int k = 0; k < 9; k++) w[k] = int'($urandom & 32'h00FF_FFFF);
      if (fno == 1 && g == 0) begin
        w[0] = 32'h00C0_0000;
        w[1] = 32'h0080_0001;
      end
      if (fno == 1 && g == 1) begin
        for (int k = 1; k < 9; k++) w[k] = 32'h007F_FFFF;
        w[3] = 32'h0012_3456;
      end
      v = w[CS + 1];
      if (v >= 32'h0080_0000) v = v - 32'h0100_0000;
      xe = v;
      se = w[0][23:0];
      q.push_back({xe, se});
      idx = 0;
      cs_falls[g]++;
    end

    // Device launches the next bit (MSB first) on each SCLK rising edge
    always @(posedge sclk_a[g]) begin
      if (idx < FB) begin
        miso_l = w[idx / 24][23 - (idx % 24)];
        idx++;
      end
    end

    // Monitor: SCLK shape, edge count, latency and delivered words
    always @(negedge clk) begin
      logic [55:0] e;
      if (!rst_n[g]) begin
        q.delete();
        x_last[g]  = '0;
        st_last[g] = '0;
        pcs   = 1'b1;
        psclk = 1'b0;
        pxv   = 1'b0;
      end else begin
        if (pcs && !cs_n_a[g]) begin
          t_start = cyc;
          sr   = 0;
          run  = 1;
          pbad = 0;
        end else if (!cs_n_a[g]) begin
          if (sclk_a[g] != psclk) begin
            if (run != CD) pbad++;
            run = 1;
          end else begin
            run++;
          end
        end
        if (sclk_a[g] && !psclk) begin
          if (cs_n_a[g]) stray[g]++;
          else sr++;
        end
        if (xv_a[g]) begin
          check("x_valid_single_cycle", g, pxv, 0);
          if (q.size() == 0) begin
            check("x_valid_expected", g, q.size(), 1);
          end else begin
            e = q.pop_front();
            check("x", g, x_a[g], e[55:24]);
            check("status", g, st_a[g], e[23:0]);
            check("latency", g, cyc - t_start, CD * (2 * FB + 2));
            check("sclk_rises", g, sr, FB);
            check("sclk_phase_errs", g, pbad, 0);
            check("cs_n_at_valid", g, cs_n_a[g], 1);
            x_last[g]  = e[55:24];
            st_last[g] = e[23:0];
            got[g]++;
          end
        end
        pcs   = cs_n_a[g];
        psclk = sclk_a[g];
        pxv   = xv_a[g];
      end
    end
  end

  task automatic trigger();
    @(negedge clk) drdy_n = 1'b0;
    repeat (6) @(negedge clk);
    drdy_n = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      ok = 1'b1;
      for (int i = 0; i < 3; i++) if (got[i] != exp_deliv[i]) ok = 1'b0;
      if (ok) break;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("frames_delivered", i, got[i], exp_deliv[i]);
      check("frames_started", i, cs_falls[i], exp_starts[i]);
      check("overrun", i, ovr_a[i], ovr_exp[i]);
    end
  endtask

  task automatic start_frame();
    for (int i = 0; i < 3; i++) begin
      check("x_hold", i, x_a[i], x_last[i]);
      check("status_hold", i, st_a[i], st_last[i]);
    end
    trigger();
    for (int i = 0; i < 3; i++) begin
      exp_starts[i]++;
      exp_deliv[i]++;
    end
  endtask

  task automatic pulse_reset(input logic [2:0] m);
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) if (m[i]) rst_n[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (m[i]) begin
        check("rst_cs_n", i, cs_n_a[i], 1);
        check("rst_sclk", i, sclk_a[i], 0);
        check("rst_x", i, x_a[i], 0);
        check("rst_x_valid", i, xv_a[i], 0);
        check("rst_status", i, st_a[i], 0);
        check("rst_overrun", i, ovr_a[i], 0);
        ovr_exp[i] = 1'b0;
      end
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      check("reset_cs_n", i, cs_n_a[i], 1);
      check("reset_sclk", i, sclk_a[i], 0);
      check("reset_x", i, x_a[i], 0);
      check("reset_x_valid", i, xv_a[i], 0);
      check("reset_status", i, st_a[i], 0);
      check("reset_overrun", i, ovr_a[i], 0);
    end
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    repeat (5) @(negedge clk);

    // fixed first frame, then random frames
    start_frame();
    wait_done(2500);
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(5, 200)) @(negedge clk);
      start_frame();
      wait_done(2500);
    end

    // second DRDY edge during a frame
    start_frame();
    repeat (300) @(negedge clk);
    trigger();
    for (int i = 0; i < 3; i++) ovr_exp[i] = 1'b1;
    wait_done(2500);
    repeat (200) @(negedge clk);
    start_frame();
    wait_done(2500);

    // DRDY while disabled is ignored
    @(negedge clk) enable = 1'b0;
    trigger();
    repeat (2500) @(negedge clk);
    for (int i = 0; i < 3; i++) check("disabled_sclk_stray", i, stray[i], 0);
    wait_done(1);

    // enable dropped mid-frame still delivers
    @(negedge clk) enable = 1'b1;
    start_frame();
    repeat (300) @(negedge clk);
    enable = 1'b0;
    wait_done(2500);
    @(negedge clk) enable = 1'b1;

    // reset in the middle of a frame
    trigger();
    for (int i = 0; i < 3; i++) exp_starts[i]++;
    repeat (200) @(negedge clk);
    pulse_reset(3'b100);
    repeat (600) @(negedge clk);
    pulse_reset(3'b011);
    repeat (1500) @(negedge clk);
    wait_done(1);

    // recovery and more random frames
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(5, 200)) @(negedge clk);
      start_frame();
      wait_done(2500);
    end
    for (int i = 0; i < 3; i++) check("sclk_stray_total", i, stray[i], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ads1299_frame_reader.md
# ads1299_frame_reader

SPI front-end that feeds the lock-in chain. It waits for the ADS1299 data-ready strobe and clocks out one full RDATAC frame: a 24-bit status word plus N_CH 24-bit channel words. It then emits the selected channel as a sign-extended sample with a one-cycle valid strobe. Its `x`/`x_valid` outputs drive the `x`/`x_valid` inputs of the lock-in wrapper directly.

## Interface
- `CLK_DIV`, default 4: clk cycles per SCLK half-period. Must be ≥ 4.
- `N_CH`, default 8: channel words per frame, range 1..8.
- `CH_SEL`, default 0: channel index (0-based) delivered on `x`.
- `Q_out`, default 32: width of `x`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, new frames are not started.
- `drdy_n`  in  1  ADS1299 DRDY, asynchronous, active-low.
- `miso`  in  1  ADS1299 DOUT, asynchronous.
- `sclk`  out  1  SPI clock (CPOL=0, CPHA=1).
- `cs_n`  out  1  SPI chip select, active-low.
- `x`  out  Q_out  selected channel, 24-bit two's complement sign-extended to Q_out.
- `x_valid`  out  1  one-cycle strobe qualifying `x`.
- `status`  out  24  status word of the last completed frame.
- `overrun`  out  1  sticky flag: a DRDY edge arrived while a frame was in progress.

## Operation
- `drdy_n` and `miso` each pass through a 2-flop synchronizer. A falling edge on synchronized `drdy_n` is the trigger.
- Frame length is FB = 24·(N_CH+1) bits; default is 216.
- State machine states:
  - IDLE: `cs_n`=1, `sclk`=0. Trigger with `enable`=1 goes to SETUP. Trigger with `enable`=0 is ignored.
  - SETUP: `cs_n`=0, `sclk`=0 for CLK_DIV cycles, then SHIFT.
  - SHIFT: FB bit periods. Each period is `sclk`=1 for CLK_DIV cycles, then `sclk`=0 for CLK_DIV cycles. Synchronized `miso` is shifted in MSB-first in the last cycle of each high phase (the cycle in which `sclk` is about to fall). After bit FB−1's low phase, go to HOLD.
  - HOLD: `cs_n`=0, `sclk`=0 for CLK_DIV cycles, then DONE.
  - DONE: one cycle. `cs_n`=1. `x_valid`=1. `x` is loaded with channel CH_SEL sign-extended from bit 23. `status` is loaded with bits 0..23 of the frame. Then IDLE.
- Word capture:
  - A bit counter selects the destination: bits 0..23 go to status; bits 24·(CH_SEL+1) .. 24·(CH_SEL+1)+23 go to the channel register.
  - All other channel words are clocked out and discarded.
  - No full-frame buffer is kept.
- Overrun:
  - A trigger in any state other than IDLE sets `overrun`=1.
  - The current frame continues unaffected. The extra trigger is dropped and does not start a new frame.
  - `overrun` clears only on reset.
- `enable` falling mid-frame: the frame completes and is delivered normally.
- Reset mid-frame, asynchronous:
  - All outputs go to their reset values immediately.
  - The bit counter clears. The partial frame is lost.
  - No `x_valid` is produced for that frame.
- `x` and `status` hold their values between frames.

## Timing
- Reset values: `sclk`=0, `cs_n`=1, `x`=0, `x_valid`=0, `status`=0, `overrun`=0; FSM in IDLE; synchronizers cleared to `drdy_n`=1 and `miso`=0.
- Trigger latency: `cs_n` falls at the 3rd `clk` rising edge after the first edge that samples `drdy_n` low (2 synchronizer stages plus edge detect).
- First `sclk` rise occurs CLK_DIV cycles after `cs_n` falls.
- `cs_n` low to `x_valid` high: CLK_DIV·(2·FB+2) cycles. Default is 1736.
- `x_valid` is high exactly one cycle, in the same cycle `cs_n` returns high.
- Minimum SCLK period is 8 clk. The 2-cycle `miso` synchronizer delay fits inside the CLK_DIV-cycle high phase, so data launched on the SCLK rising edge is stable when sampled.
- Back-to-back frames: a trigger arriving in the DONE cycle counts as overrun. A trigger arriving one cycle later in IDLE starts a new frame.

## Test plan
- Default parameters; ADS1299 model returns status 0xC00000 and ch0=0x800001 → exactly 216 `sclk` rising edges; `status`=0xC00000; `x`=0xFF800001; `x_valid` is a single pulse 1736 cycles after `cs_n` falls.
- CH_SEL=2; ch2=0x123456, all other channels 0x7FFFFF → `x`=0x00123456. Check `x` is unchanged until the next frame.
- Second `drdy_n` falling edge 500 cycles into a frame → `overrun`=1; exactly one `x_valid` for that frame; `overrun` stays 1 through later frames.
- `enable`=0 when `drdy_n` falls → `cs_n` stays 1, no `sclk` edges, no `x_valid`. Drop `enable` mid-frame → the frame still delivers `x_valid`.
- Assert `reset_n` low for 1 cycle at bit 100 → `cs_n`=1, `sclk`=0, `x`=0 immediately; no `x_valid`. The next `drdy_n` edge yields a correct frame.
- N_CH=1, CLK_DIV=5 → 48 bits; `cs_n`-low to `x_valid` = 490 cycles; `sclk` high and low phases are each exactly 5 cycles.
